// File: rtl/ref_row_streamer_pkg.sv
// Shared constants and FSM encoding for the reference row streamer.
// The block height covers 8 output rows plus the 7 extra rows the 8-tap filter needs.
package ref_row_streamer_pkg;

  localparam int PIX_W       = 8;
  localparam int ROW_PIX     = 15;
  localparam int BLK_ROWS    = 8;
  localparam int FILTER_TAPS = 7;
  localparam int ROWS        = BLK_ROWS + FILTER_TAPS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/ref_row_streamer_fifo.sv
// Two-entry first-word-fall-through row FIFO; head is the oldest entry.
// A push and a pop in the same cycle are accepted at any occupancy.
module row_fifo2 #(
  parameter int WIDTH = 120
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] entry_q [2];
  logic [WIDTH-1:0] entry_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic             pop_ok;
  logic             push_ok;

  always_comb begin
    pop_ok   = pop && (occ_q != 2'd0);
    // A full FIFO can still take a write when the head leaves in the same cycle.
    push_ok  = push && ((occ_q != 2'd2) || pop_ok);
    entry_d  = entry_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_ok) begin
      entry_d[wr_ptr_q] = wdata;
      wr_ptr_d          = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    occ_d = occ_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      entry_q  <= entry_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign occ  = occ_q;
  assign head = entry_q[rd_ptr_q];

endmodule

// File: rtl/ref_row_streamer.sv
// Fetches a ROWS x ROW_PIX reference block row by row, clamping row indices to the
// picture, and streams the rows to the interpolator over a valid/ready handshake.
module ref_row_streamer
  import ref_row_streamer_pkg::*;
#(
  parameter int PIC_ROWS = 64,
  parameter int ADDR_W   = 8,
  parameter int Y_W      = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [Y_W-1:0]           start_y,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_rd,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [ROW_PIX*PIX_W-1:0] mem_rdata,
  output logic [ROW_PIX*PIX_W-1:0] in_row,
  output logic                     row_valid,
  input  logic                     row_ready,
  output logic [7:0]               row_idx
);

  localparam int ROW_W = ROW_PIX * PIX_W;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0]   LAST_ROW    = CNT_W'(ROWS - 1);
  localparam logic signed [Y_W:0] PIC_ROWS_S = (Y_W + 1)'(PIC_ROWS);
  localparam logic [ADDR_W-1:0]  BOTTOM_ADDR = ADDR_W'(PIC_ROWS - 1);

  state_e           state_q, state_d;
  logic [Y_W-1:0]   start_y_q, start_y_d;
  logic [CNT_W-1:0] issue_q, issue_d;
  logic [CNT_W-1:0] xfer_q, xfer_d;
  logic             inflight_q, inflight_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [1:0]       fifo_occ;
  logic [ROW_W-1:0] fifo_head;
  logic             pop;
  logic [2:0]       buffered;
  logic             issue_ok;
  logic signed [Y_W:0] y_ext;
  logic [ADDR_W-1:0]   clamp_addr;

  row_fifo2 #(.WIDTH(ROW_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .wdata (mem_rdata),
    .pop   (pop),
    .occ   (fifo_occ),
    .head  (fifo_head)
  );

  assign row_valid = (fifo_occ != 2'd0);
  assign pop       = row_valid && row_ready;
  assign in_row    = fifo_head;
  assign row_idx   = {{(8 - CNT_W){1'b0}}, xfer_q};

  // Count the row already in flight so returning data always finds a free slot.
  assign buffered = {1'b0, fifo_occ} + {2'b00, inflight_q};
  assign issue_ok = buffered < (3'd2 + {2'b00, pop});
  assign mem_rd   = (state_q == ST_FETCH) && issue_ok;

  // Vertical padding: rows above the picture repeat row 0, rows below repeat the last.
  assign y_ext = $signed({start_y_q[Y_W-1], start_y_q})
               + $signed({{(Y_W + 1 - CNT_W){1'b0}}, issue_q});

  always_comb begin
    if (y_ext < 0) begin
      clamp_addr = '0;
    end else if (y_ext >= PIC_ROWS_S) begin
      clamp_addr = BOTTOM_ADDR;
    end else begin
      clamp_addr = y_ext[ADDR_W-1:0];
    end
  end

  assign mem_addr = mem_rd ? clamp_addr : '0;

  always_comb begin
    state_d    = state_q;
    start_y_d  = start_y_q;
    issue_d    = issue_q;
    xfer_d     = xfer_q;
    inflight_d = mem_rd;

    if (pop) begin
      xfer_d = xfer_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_y_d = start_y;
          issue_d   = '0;
          xfer_d    = '0;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (mem_rd) begin
          issue_d = issue_q + 1'b1;
          if (issue_q == LAST_ROW) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pop && (xfer_q == LAST_ROW)) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_FIN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      start_y_q  <= '0;
      issue_q    <= '0;
      xfer_q     <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_y_q  <= start_y_d;
      issue_q    <= issue_d;
      xfer_q     <= xfer_d;
      inflight_q <= inflight_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_ref_row_streamer.sv
// Randomised bench for ref_row_streamer with a row-memory model and a clamp-based
// reference for the expected address and row sequence of every block.
module tb_ref_row_streamer;
  import ref_row_streamer_pkg::*;

  localparam int W    = ROW_PIX * PIX_W;
  localparam int PICR = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [8:0]   start_y = '0;
  logic         busy, done, mem_rd;
  logic [7:0]   mem_addr;
  logic [W-1:0] mem_rdata = '0;
  logic [W-1:0] in_row;
  logic         row_valid;
  logic         row_ready = 1'b0;
  logic [7:0]   row_idx;

  logic [W-1:0] mem [PICR];
  int n_vec = 0;
  int n_err = 0;

  ref_row_streamer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_y   (start_y),
    .busy      (busy),
    .done      (done),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .in_row    (in_row),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_idx   (row_idx)
  );

  always #5 clk = ~clk;

  // Memory answers one cycle after the strobe; otherwise it drives junk.
  always @(posedge clk) begin
    logic [127:0] junk;
    junk = {$urandom, $urandom, $urandom, $urandom};
    if (mem_rd && (mem_addr < 8'(PICR))) mem_rdata <= mem[mem_addr[5:0]];
    else mem_rdata <= junk[W-1:0];
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int clampy(input int y);
    if (y < 0) return 0;
    if (y > PICR - 1) return PICR - 1;
    return y;
  endfunction

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"},      W'(busy),      '0);
    chk({tag, "_done"},      W'(done),      '0);
    chk({tag, "_mem_rd"},    W'(mem_rd),    '0);
    chk({tag, "_row_valid"}, W'(row_valid), '0);
    chk({tag, "_in_row"},    in_row,        '0);
    chk({tag, "_mem_addr"},  W'(mem_addr),  '0);
    chk({tag, "_row_idx"},   W'(row_idx),   '0);
  endtask

  // mode 0: ready always high, 1: stall cycles 4..9 then random, 2: random.
  task automatic run_block(input int sy, input int mode, input int ign_a, input int ign_b,
                           input int rst_c);
    int exp_a [ROWS];
    int issued, xfers, pops;
    bit fin, prev_stall;
    logic [W-1:0] prev_row;
    for (int k = 0; k < ROWS; k++) exp_a[k] = clampy(sy + k);
    issued = 0; xfers = 0; fin = 1'b0; prev_stall = 1'b0; prev_row = '0;
    @(negedge clk);
    start = 1'b1; start_y = 9'(sy); row_ready = 1'b1;
    for (int c = 1; c <= 300 && !fin; c++) begin
      @(negedge clk);
      start = (c == ign_a) || (c == ign_b);
      if (start) start_y = 9'($urandom_range(0, 63));
      case (mode)
        0:       row_ready = 1'b1;
        1:       row_ready = (c < 4) ? 1'b1 : (c <= 9) ? 1'b0 : ($urandom_range(0, 3) != 0);
        default: row_ready = 1'($urandom_range(0, 1));
      endcase
      if (rst_c != 0 && c == rst_c) rst = 1'b0;
      if (rst_c != 0 && c == rst_c + 1) begin
        rst = 1'b1;
        #1;
        chk_zero_outputs("post_rst");
        for (int k = 0; k < 3; k++) begin
          @(negedge clk); #1;
          chk("stale_valid", W'(row_valid), '0);
          chk("stale_busy",  W'(busy),      '0);
        end
        return;
      end
      #1;
      if (mode == 0) begin
        chk("t_mem_rd", W'(mem_rd),    W'(c >= 1 && c <= 15));
        chk("t_valid",  W'(row_valid), W'(c >= 3 && c <= 17));
        chk("t_busy",   W'(busy),      W'(c >= 1 && c <= 17));
        chk("t_done",   W'(done),      W'(c == 18));
      end
      if (prev_stall) begin
        chk("stall_valid", W'(row_valid), W'(1));
        chk("stall_row",   in_row,        prev_row);
      end
      pops = (row_valid && row_ready) ? 1 : 0;
      if (mem_rd) begin
        if (issued >= ROWS) chk("extra_rd", W'(issued), W'(ROWS - 1));
        else chk("addr", W'(mem_addr), W'(exp_a[issued]));
        chk("buf_limit", W'((issued + 1) - (xfers + pops) <= 2), W'(1));
        issued++;
      end
      if (pops == 1) begin
        if (xfers >= ROWS) chk("extra_xfer", W'(xfers), W'(ROWS - 1));
        else begin
          chk("row_idx", W'(row_idx), W'(xfers));
          chk("in_row",  in_row,      mem[exp_a[xfers]]);
          $display("xfer start_y=%0d row=%0d mem_row=%0d", sy, xfers, exp_a[xfers]);
        end
        xfers++;
      end
      prev_stall = row_valid && !row_ready;
      prev_row   = in_row;
      if (done) begin
        fin = 1'b1;
        chk("done_issued", W'(issued), W'(ROWS));
        chk("done_xfers",  W'(xfers),  W'(ROWS));
      end
    end
    if (!fin) chk("timeout", W'(0), W'(1));
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("after_done", W'(done), '0);
    chk("after_busy", W'(busy), '0);
  endtask

  initial begin
    for (int r = 0; r < PICR; r++) begin
      logic [127:0] v;
      v = {$urandom, $urandom, $urandom, $urandom};
      mem[r] = v[W-1:0];
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_zero_outputs("reset");
    rst = 1'b1;
    run_block(0, 0, 0, 0, 0);
    run_block(-3, 0, 0, 0, 0);
    run_block(55, 0, 0, 0, 0);
    run_block(20, 1, 0, 0, 0);
    run_block(5, 0, 6, 18, 0);
    run_block(30, 2, 0, 0, 0);
    run_block(20, 0, 0, 0, 7);
    run_block(10, 0, 0, 0, 0);
    for (int n = 0; n < 4; n++) run_block(int'($urandom_range(0, 90)) - 20, 2, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ref_row_streamer.md
Name: ref_row_streamer

Overview:
- Source side of the interpolator row interface: fetches a 15x15 reference block, one 15-pixel row per access, from the row-wide reference memory.
- Streams the rows in order onto in_row using a valid/ready handshake. row_ready is driven from the interpolator's load_in.
- Applies HEVC vertical boundary padding by clamping row indices to the picture.
- Sits between the reference-picture SRAM and the subpixel interpolation top.

Parameters:
- PIX_W, 8, bits per pixel
- ROW_PIX, 15, pixels per row (in_row width = ROW_PIX*PIX_W = 120)
- ROWS, 15, rows per block (8 output + 7 filter taps)
- PIC_ROWS, 64, picture height in rows; valid row indices 0..PIC_ROWS-1
- ADDR_W, 8, memory row address width
- Y_W, 9, width of signed start row

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-low
- start  in  1  single-cycle request; sampled only in IDLE
- start_y  in  Y_W  signed top row of block; may be negative or exceed the picture
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last row transfer
- mem_rd  out  1  memory read strobe
- mem_addr  out  ADDR_W  row address, valid with mem_rd
- mem_rdata  in  ROW_PIX*PIX_W  read data, valid exactly 1 cycle after mem_rd
- in_row  out  ROW_PIX*PIX_W  row to interpolator; pixel 0 in bits [PIX_W-1:0]
- row_valid  out  1  in_row holds a row
- row_ready  in  1  downstream accepts; a transfer occurs when row_valid && row_ready
- row_idx  out  8  block-relative index (0..ROWS-1) of the row on in_row

Behaviour:
- Reset (rst==0 at a clock edge): the FSM goes to IDLE. busy, done, mem_rd, row_valid are 0. in_row, mem_addr, row_idx are 0. The FIFO is emptied, the in-flight flag is cleared and all counters are cleared. A read issued before reset returns data that is never written.
- FSM states: IDLE, FETCH, DRAIN, FIN.
  - IDLE: on start=1, latch start_y, clear issue count i and transfer count t, go to FETCH.
  - FETCH: issues reads. Go to DRAIN in the cycle the ROWS-th read issues.
  - DRAIN: no reads. Go to FIN on the transfer with t==ROWS-1.
  - FIN: done=1 for one cycle, then IDLE.
  - busy=1 in FETCH and DRAIN.
- start while busy or in FIN is ignored. No queuing.
- Address clamp: y = start_y + i, computed at Y_W+1 bits signed.
  - mem_addr = 0 if y<0.
  - mem_addr = PIC_ROWS-1 if y>=PIC_ROWS.
  - Otherwise mem_addr = y.
- Buffering is a 2-entry FIFO of rows plus a 1-bit in-flight flag (mem_rd was asserted last cycle).
  - A read issues in FETCH when occ + inflight - pop < 2, where pop = row_valid && row_ready this cycle.
  - This guarantees that returning data always has space.
  - With row_ready held high, one row transfers per cycle.
- mem_rdata is written into the FIFO at the end of the cycle after mem_rd.
- row_valid = (occ != 0).
- in_row and row_idx come from the FIFO head. row_idx = t.
- Simultaneous write and pop is legal at any occupancy; occ is unchanged.
- Latency, with start accepted at cycle 0 and row_ready=1 throughout:
  - mem_rd in cycles 1..15.
  - row_valid in cycles 3..17.
  - done in cycle 18.
  - busy in cycles 1..17.
- in_row and row_idx are stable while row_valid && !row_ready (no change until the transfer).
- row_ready is ignored when row_valid=0.

Decomposition:
- Shared package (the codebase's constant include alongside library.v) holds:
  - PIX_W and ROW_PIX
  - the ROWS derivation (block size + 7 taps)
  - the FSM state encodings IDLE=0, FETCH=1, DRAIN=2, FIN=3
- One natural sub-module: row_fifo2 — a 2-deep, WIDTH-parameterised, first-word-fall-through FIFO with push, pop, occ[1:0], head.
- The clamp is inline.

Test Plan:
- Basic stream: start_y=0, row_ready=1.
  - mem_addr 0..14 in cycles 1..15.
  - 15 transfers with row_idx 0..14 in cycles 3..17; in_row equals the memory model rows.
  - done pulses in cycle 18 only.
- Top clamp: start_y=-3.
  - Addresses 0,0,0,0,1,2,...,11.
  - The first four transferred rows are identical.
- Bottom clamp: start_y=55, PIC_ROWS=64.
  - Addresses 55..63, then 63 six times.
  - The last seven rows equal memory row 63.
- Backpressure: row_ready=0 in cycles 4..9, random thereafter.
  - At most 2 rows are buffered and no mem_rd is issued while the FIFO is full.
  - in_row is stable while stalled.
  - All 15 rows arrive exactly once, in order.
- start pulsed in cycle 6 of an active block: ignored, and the block finishes normally. A start during FIN is also ignored.
- Reset mid-operation: rst=0 in cycle 7 (mem_rd active in cycle 6).
  - Next cycle: all outputs are 0 and occ=0.
  - The stale mem_rdata is not presented.
  - A new start_y=10 then streams rows 10..24 (clamped at 63 as applicable) correctly.
